// File: rtl/sum_list_ctrl.sv
// Control FSM for a linked-list summing datapath: walks (link, data) word pairs until a zero link.
// Optional node-limit abort is compiled in when NODE_LIMIT_EN is defined.
module sum_list_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_NODES  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  next_zero,
  output logic                  ld_sum,
  output logic                  ld_next,
  output logic                  sum_sel,
  output logic                  next_sel,
  output logic                  a_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] node_cnt
);

  typedef enum logic [2:0] {IDLE, INIT, ADD, LINK, DONE} state_t;

  state_t state, state_nxt;
  logic   limit_hit;
  logic   run_active;

  if ((MAX_NODES < 1) || (64'(MAX_NODES) >= (64'd1 << DATA_WIDTH))) begin : g_max_nodes_out_of_range
  end

`ifdef NODE_LIMIT_EN
  localparam logic [DATA_WIDTH-1:0] NODE_LIMIT = DATA_WIDTH'(MAX_NODES);
  logic limit_abort;

  assign limit_hit   = (node_cnt == NODE_LIMIT);
  assign limit_abort = (state == LINK) && !next_zero && limit_hit && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (limit_abort) begin
      err <= 1'b1;
    end
  end
`else
  assign limit_hit = 1'b0;
  assign err       = 1'b0;
`endif

  assign run_active = (state == INIT) || (state == ADD) || (state == LINK);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = ADD;
      ADD:     state_nxt = LINK;
      LINK: begin
        if (next_zero)      state_nxt = DONE;
        else if (limit_hit) state_nxt = IDLE;
        else                state_nxt = ADD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stop && run_active) state_nxt = IDLE;
  end

  // Outputs are decoded from the next state so they stay aligned with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ld_sum   <= 1'b0;
      ld_next  <= 1'b0;
      sum_sel  <= 1'b0;
      next_sel <= 1'b0;
      a_sel    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      node_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ld_sum   <= (state_nxt == INIT) || (state_nxt == ADD);
      ld_next  <= (state_nxt == INIT) || (state_nxt == LINK);
      sum_sel  <= (state_nxt == INIT);
      next_sel <= (state_nxt == INIT);
      a_sel    <= (state_nxt == LINK);
      busy     <= (state_nxt == INIT) || (state_nxt == ADD) || (state_nxt == LINK);
      done     <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        node_cnt <= '0;
      end else if (state_nxt == ADD && node_cnt != '1) begin
        node_cnt <= node_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_list_ctrl.sv
// Bench for sum_list_ctrl: memory + datapath model around the DUT, list-walk reference model, done-driven scoreboard.
module tb_sum_list_ctrl;
  localparam int unsigned W    = 8;
  localparam int unsigned MAXN = 4;

  logic clk = 1'b0;
  logic rst, start, stop, next_zero;
  logic ld_sum, ld_next, sum_sel, next_sel, a_sel, busy, done, err;
  logic [W-1:0] node_cnt;

  logic [W-1:0] mem [256];
  logic [W-1:0] sum_r, next_r, addr, din;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] cnt;
    int           start_cyc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  sum_list_ctrl #(.DATA_WIDTH(W), .MAX_NODES(MAXN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .next_zero(next_zero),
    .ld_sum(ld_sum), .ld_next(ld_next), .sum_sel(sum_sel), .next_sel(next_sel),
    .a_sel(a_sel), .busy(busy), .done(done), .err(err), .node_cnt(node_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    addr      = a_sel ? next_r : next_r + 8'd1;
    din       = mem[addr];
    next_zero = ((next_sel ? 8'd0 : din) == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      next_r <= '0;
    end else begin
      if (ld_sum)  sum_r  <= sum_sel ? 8'd0 : sum_r + din;
      if (ld_next) next_r <= next_sel ? 8'd0 : din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum_r), 32'(e.sum));
        check("node_cnt_at_done", 32'(node_cnt), 32'(e.cnt));
        check("err_at_done", 32'(err), 32'd0);
        check("done_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Walk the list from address 0: data at p+1, link at p, stop at a zero link.
  function automatic void model(output logic [W-1:0] s, output logic [W-1:0] n,
                                output logic e, output int nodes);
    logic [W-1:0] p, q;
    p = '0; s = '0; n = '0; e = 1'b0; nodes = 0;
    for (int i = 0; i < 1000; i++) begin
      nodes++;
      if (n != 8'hFF) n = n + 8'd1;
      q = p + 8'd1;
      s = s + mem[q];
      if (mem[p] == 8'd0) break;
`ifdef NODE_LIMIT_EN
      if (n == 8'(MAXN)) begin
        e = 1'b1;
        break;
      end
`endif
      p = mem[p];
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_list(input bit restart_mid, input bit stop_with_start);
    logic [W-1:0] s, n;
    logic e;
    int nodes, d0;
    exp_t x;
    model(s, n, e, nodes);
    d0 = done_seen;
    if (!e) begin
      x.sum = s; x.cnt = n; x.start_cyc = cyc; x.lat = 2 * nodes + 2;
      exp_q.push_back(x);
    end
    start = 1'b1;
    stop  = stop_with_start;
    step();
    start = 1'b0;
    stop  = 1'b0;
    if (restart_mid) begin
      step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 700; i++) begin
      if (e ? !busy : (done_seen != d0)) break;
      step();
    end
    if (e) begin
      check("limit_err", 32'(err), 32'd1);
      check("limit_node_cnt", 32'(node_cnt), 32'(n));
      check("limit_no_done", 32'(done_seen - d0), 32'd0);
    end else begin
      check("done_count", 32'(done_seen - d0), 32'd1);
      step();
      check("done_one_cycle", 32'(done), 32'd0);
    end
    step();
  endtask

  task automatic clear_mem();
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic load_two_node();
    clear_mem();
    mem[0] = 8'd4; mem[1] = 8'd5; mem[4] = 8'd0; mem[5] = 8'd7;
  endtask

  task automatic load_one_node();
    clear_mem();
    mem[0] = 8'd0; mem[1] = 8'd9;
  endtask

  task automatic load_random_list(input int unsigned nn);
    logic [W-1:0] a [8];
    int unsigned b;
    b = $urandom_range(0, 126);
    a[0] = 8'd0;
    for (int unsigned i = 1; i < nn; i++) a[i] = 8'(2 * (((b + i * 37) % 127) + 1));
    clear_mem();
    for (int unsigned i = 0; i < nn; i++) begin
      mem[a[i]]        = (i == nn - 1) ? 8'd0 : a[i + 1];
      mem[a[i] + 8'd1] = 8'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    clear_mem();
    step();
    step();
    check("reset_outputs",
          32'({ld_sum, ld_next, sum_sel, next_sel, a_sel, busy, done, err, node_cnt}), 32'd0);
    rst = 1'b0;
    step();

    load_two_node();
    run_list(1'b0, 1'b0);
    check("two_node_err", 32'(err), 32'd0);

    load_one_node();
    run_list(1'b0, 1'b0);

    // Stop during the second ADD, then a clean rerun.
    load_two_node();
    d0 = done_seen;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("in_second_add", 32'({busy, ld_sum, sum_sel, a_sel}), 32'b1100);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_node_cnt", 32'(node_cnt), 32'd2);
    step(); step(); step();
    check("stop_no_done", 32'(done_seen - d0), 32'd0);
    run_list(1'b0, 1'b0);

    // Second start inside a run is dropped.
    load_two_node();
    run_list(1'b1, 1'b0);

    // Stop alongside start in IDLE is ignored.
    load_one_node();
    run_list(1'b0, 1'b1);

    // Stop coinciding with the LINK exit to DONE wins.
    load_one_node();
    d0 = done_seen;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    check("in_final_link", 32'({a_sel, next_zero}), 32'b11);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_link_busy", 32'(busy), 32'd0);
    check("stop_link_cnt", 32'(node_cnt), 32'd1);
    step(); step(); step();
    check("stop_link_no_done", 32'(done_seen - d0), 32'd0);

    // Reset mid-LINK.
    load_two_node();
    d0 = done_seen;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    check("in_link_before_rst", 32'(a_sel), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs",
          32'({ld_sum, ld_next, sum_sel, next_sel, a_sel, busy, done, err, node_cnt}), 32'd0);
    step();
    rst = 1'b0;
    step(); step(); step(); step();
    check("rst_mid_no_done", 32'(done_seen - d0), 32'd0);

    // Cyclic list.
    clear_mem();
    mem[0] = 8'd2; mem[2] = 8'd2;
`ifdef NODE_LIMIT_EN
    run_list(1'b0, 1'b0);
    check("limit_idle", 32'(busy), 32'd0);
`else
    d0 = done_seen;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 700; i++) step();
    check("cyclic_no_done", 32'(done_seen - d0), 32'd0);
    check("cyclic_busy", 32'(busy), 32'd1);
    check("cyclic_cnt_saturates", 32'(node_cnt), 32'd255);
    check("cyclic_err", 32'(err), 32'd0);
    stop = 1'b1; step(); stop = 1'b0;
    check("cyclic_stop_idle", 32'(busy), 32'd0);
    check("cyclic_stop_cnt", 32'(node_cnt), 32'd255);
    step();
`endif

    for (int k = 0; k < 30; k++) begin
      load_random_list($urandom_range(1, 7));
      run_list(($urandom_range(0, 3) == 0), 1'b0);
    end

    step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
